// File: rtl/integ_decim.sv
// Cascaded CIC integrator chain with decimating output register.
// Optional macro INTEG_DECIM_SYNC_EN adds samp_sync for decimation phase alignment.
module integ_decim #(
  parameter int INP_WIDTH  = 8,
  parameter int SAMP_WIDTH = 24,
  parameter int CIC_N      = 3,
  parameter int CIC_R      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INP_WIDTH-1:0]  samp_inp_data,
  input  logic                  samp_inp_str,
`ifdef INTEG_DECIM_SYNC_EN
  input  logic                  samp_sync,
`endif
  output logic [SAMP_WIDTH-1:0] samp_out_data,
  output logic                  samp_out_str
);

  localparam int CNT_W = (CIC_R > 1) ? $clog2(CIC_R) : 1;

  logic [SAMP_WIDTH-1:0] inp_ext;
  logic [SAMP_WIDTH-1:0] acc_reg  [CIC_N];
  logic [SAMP_WIDTH-1:0] acc_next [CIC_N];
  logic [CNT_W-1:0]      dec_cnt_reg;
  logic [CNT_W-1:0]      dec_cnt_next;
  logic [CNT_W-1:0]      cnt_eff;
  logic                  out_fire;
  logic [SAMP_WIDTH-1:0] out_data_reg;
  logic                  out_str_reg;

  assign inp_ext = SAMP_WIDTH'($signed(samp_inp_data));

  // Each stage adds the pre-edge value of its predecessor, so the chain is pipelined.
  generate
    for (genvar gi = 0; gi < CIC_N; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign acc_next[gi] = acc_reg[gi] + inp_ext;
      end else begin : g_rest
        assign acc_next[gi] = acc_reg[gi] + acc_reg[gi-1];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          acc_reg[gi] <= '0;
        end else if (samp_inp_str) begin
          acc_reg[gi] <= acc_next[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    cnt_eff = dec_cnt_reg;
`ifdef INTEG_DECIM_SYNC_EN
    // A sync pulse makes the current (or next) strobe phase zero.
    if (samp_sync) begin
      cnt_eff = '0;
    end
`endif
    out_fire     = samp_inp_str && (cnt_eff == CNT_W'(CIC_R - 1));
    dec_cnt_next = cnt_eff;
    if (samp_inp_str) begin
      dec_cnt_next = out_fire ? '0 : cnt_eff + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_cnt_reg  <= '0;
      out_str_reg  <= 1'b0;
      out_data_reg <= '0;
    end else begin
      dec_cnt_reg <= dec_cnt_next;
      out_str_reg <= out_fire;
      if (out_fire) begin
        out_data_reg <= acc_next[CIC_N-1];
      end
    end
  end

  assign samp_out_data = out_data_reg;
  assign samp_out_str  = out_str_reg;

endmodule

// File: tb/tb_integ_decim.sv
// Self-checking bench for integ_decim: four parameterisations driven by a shared
// stimulus, checked every cycle against a binomial-weighted closed-form model.
module tb_integ_decim;

  localparam int NI = 4;
  localparam int R_TAB [NI] = '{8, 4, 4, 1};
  localparam int N_TAB [NI] = '{3, 3, 1, 1};
  localparam int W_TAB [NI] = '{24, 24, 24, 8};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = '0;
  logic       str = 1'b0;
  logic       sync_v = 1'b0;

  logic [23:0] d0, d1, d2;
  logic [7:0]  d3;
  logic        s0, s1, s2, s3;

  always #5 clk = ~clk;

  integ_decim u_dflt (.clk(clk), .reset(reset), .samp_inp_data(din), .samp_inp_str(str),
`ifdef INTEG_DECIM_SYNC_EN
    .samp_sync(sync_v),
`endif
    .samp_out_data(d0), .samp_out_str(s0));

  integ_decim #(.CIC_N(3), .CIC_R(4)) u_imp (.clk(clk), .reset(reset), .samp_inp_data(din),
    .samp_inp_str(str),
`ifdef INTEG_DECIM_SYNC_EN
    .samp_sync(sync_v),
`endif
    .samp_out_data(d1), .samp_out_str(s1));

  integ_decim #(.CIC_N(1), .CIC_R(4)) u_dc (.clk(clk), .reset(reset), .samp_inp_data(din),
    .samp_inp_str(str),
`ifdef INTEG_DECIM_SYNC_EN
    .samp_sync(sync_v),
`endif
    .samp_out_data(d2), .samp_out_str(s2));

  integ_decim #(.SAMP_WIDTH(8), .INP_WIDTH(8), .CIC_N(1), .CIC_R(1)) u_wrap (.clk(clk),
    .reset(reset), .samp_inp_data(din), .samp_inp_str(str),
`ifdef INTEG_DECIM_SYNC_EN
    .samp_sync(sync_v),
`endif
    .samp_out_data(d3), .samp_out_str(s3));

  int     n_assert = 0;
  int     n_fail   = 0;
  bit     armed    = 0;
  longint hist [$];
  int     since_align;
  bit     exp_str  [NI];
  longint exp_data [NI];
  longint q [NI][$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint binom(input int d, input int k);
    longint c = 1;
    if (d < k) return 0;
    for (int i = 1; i <= k; i++) c = c * (d - k + i) / i;
    return c;
  endfunction

  // Output of an N-stage pipelined integrator after the latest sample:
  // sum_j x[j] * C(n-j, N-1), reduced modulo 2^W.
  function automatic longint model_val(input int n_stg, input int w);
    longint s = 0;
    int n = hist.size() - 1;
    for (int j = 0; j <= n; j++) s += hist[j] * binom(n - j, n_stg - 1);
    return s & ((longint'(1) << w) - 1);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      hist.delete();
      since_align = 0;
      armed = 1;
      for (int i = 0; i < NI; i++) begin
        exp_str[i]  = 0;
        exp_data[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) exp_str[i] = 0;
      if (str) begin
        int idx;
        hist.push_back(longint'($signed(din)));
        idx = sync_v ? 0 : since_align;
        for (int i = 0; i < NI; i++) begin
          if (idx % R_TAB[i] == R_TAB[i] - 1) begin
            exp_str[i]  = 1;
            exp_data[i] = model_val(N_TAB[i], W_TAB[i]);
          end
        end
        since_align = idx + 1;
      end else if (sync_v) begin
        since_align = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      bit     as [NI];
      longint ad [NI];
      as = '{s0, s1, s2, s3};
      ad = '{longint'(d0), longint'(d1), longint'(d2), longint'(d3)};
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("inst%0d_str", i), longint'(as[i]), longint'(exp_str[i]));
        chk($sformatf("inst%0d_data", i), ad[i], exp_data[i]);
        if (as[i]) q[i].push_back(ad[i]);
      end
    end
  end

  task automatic step(input bit s, input logic [7:0] d, input bit sy);
    @(negedge clk);
    str = s;
    din = d;
    sync_v = sy;
  endtask

  task automatic seg_reset();
    @(negedge clk);
    reset = 1; str = 0; sync_v = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < NI; i++) q[i].delete();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 8'd0, 0);
  endtask

  task automatic chk_q(input string nm, input int inst, input int cnt,
                       input longint e0, input longint e1, input longint e2);
    longint e [3];
    e = '{e0, e1, e2};
    chk({nm, "_count"}, longint'(q[inst].size()), longint'(cnt));
    for (int k = 0; k < cnt && k < q[inst].size(); k++)
      chk($sformatf("%s_out%0d", nm, k), q[inst][k], e[k]);
  endtask

  initial begin
    // Model pins: impulse response of 3 stages at strobes 3, 7, 11.
    chk("model_binom3", binom(3, 2), 3);
    chk("model_binom7", binom(7, 2), 21);
    chk("model_binom11", binom(11, 2), 55);

    seg_reset();
    chk("reset_data", longint'(d0), 0);
    chk("reset_str", longint'(s0), 0);

    seg_reset();
    for (int k = 0; k < 12; k++) step(1, (k == 0) ? 8'd1 : 8'd0, 0);
    idle(3);
    chk_q("impulse", 1, 3, 3, 21, 55);

    seg_reset();
    for (int k = 0; k < 12; k++) begin
      step(1, (k == 0) ? 8'd1 : 8'd0, 0);
      idle(2);
    end
    idle(3);
    chk_q("gapped", 1, 3, 3, 21, 55);

    seg_reset();
    for (int k = 0; k < 12; k++) step(1, 8'd1, 0);
    idle(3);
    chk_q("dc", 2, 3, 4, 8, 12);

    seg_reset();
    step(1, 8'd127, 0);
    step(1, 8'd1, 0);
    idle(3);
    chk_q("wrap", 3, 2, 127, 128, 0);

    seg_reset();
    step(1, 8'd1, 0);
    step(1, 8'd1, 0);
    seg_reset();
    for (int k = 0; k < 4; k++) step(1, 8'd1, 0);
    idle(3);
    chk_q("reset_mid", 2, 1, 4, 0, 0);

`ifdef INTEG_DECIM_SYNC_EN
    seg_reset();
    for (int k = 0; k < 10; k++) step(1, 8'd1, k == 2);
    idle(3);
    chk_q("sync", 2, 2, 6, 10, 0);
`endif

    // Random traffic: bursts, gaps, reset colliding with strobes, optional sync.
    seg_reset();
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 149) == 0);
      str = (k % 200 < 100) ? 1'b1 : ($urandom_range(0, 2) == 0);
      din = 8'($urandom);
`ifdef INTEG_DECIM_SYNC_EN
      sync_v = ($urandom_range(0, 19) == 0);
`endif
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
